// File: rtl/msg_pkg.sv
// ----------------------------------------------------------------------------
// msg_pkg
// Shared types and constants for the message receive path.
//   pay    : 32-bit message as four packed bytes, a is the most significant.
//   MSG_W  : message width in bits.
//   DROP_W : width of the dropped-message counter (used when the optional
//            drop counter is built in via MSG_RX_FIFO_DROP_CNT_EN).
// ----------------------------------------------------------------------------
package msg_pkg;

    localparam int MSG_W  = 32;
    localparam int DROP_W = 8;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
    } pay;

endpackage : msg_pkg

// File: rtl/msg_rx_fifo_ptr_wrap.sv
// ----------------------------------------------------------------------------
// ptr_wrap
// log2(DEPTH)-bit pointer that advances by one on inc and wraps from
// DEPTH-1 back to 0. Synchronous clear on rst.
// Ports:
//   ck  : clock, rising edge
//   rst : synchronous active-high clear (wins over inc)
//   inc : advance the pointer this cycle
//   ptr : current pointer value
// ----------------------------------------------------------------------------
module ptr_wrap #(
    parameter int DEPTH = 4,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (inc) begin
            // Explicit wrap keeps the pointer correct even if the width
            // were ever wider than log2(DEPTH).
            if (ptr_reg == PW'(DEPTH - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = ptr_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule : ptr_wrap

// File: rtl/msg_rx_fifo.sv
// ----------------------------------------------------------------------------
// msg_rx_fifo
// Queues reassembled 32-bit messages from the byte-serial consumer's receive
// strobe into a DEPTH-entry in-order FIFO and hands them to the next stage
// over valid/ready. Messages arriving while full (and not being popped in the
// same cycle) are dropped and flagged on the sticky overflow output.
//
// Optional build macro: MSG_RX_FIFO_DROP_CNT_EN
//   When defined, adds the drop_cnt output: saturating count of dropped
//   messages, cleared by rst or clr_ovf.
//
// Ports:
//   ck        : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : one-cycle receive strobe, in_msg valid with it
//   in_msg    : message {a,b,c,d}
//   out_valid : head entry available
//   out_ready : sink takes the head this cycle
//   out_msg   : head entry, stable while out_valid && !out_ready
//   count     : number of stored entries
//   full      : count == DEPTH
//   empty     : count == 0
//   overflow  : sticky, at least one message dropped
//   clr_ovf   : clears overflow (and drop_cnt when present)
//   drop_cnt  : dropped-message count (optional)
// ----------------------------------------------------------------------------
module msg_rx_fifo
    import msg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              in_valid,
    input  pay                in_msg,
    output logic              out_valid,
    input  logic              out_ready,
    output pay                out_msg,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_ovf
`ifdef MSG_RX_FIFO_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] drop_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [MSG_W-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             overflow_reg;
    logic             overflow_next;

    logic             push;
    logic             pop;
    logic             drop;

    // Status is derived purely from the registered count, so out_valid
    // never depends combinationally on in_valid (no fall-through).
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign out_valid = !empty;

    assign pop  = out_valid && out_ready;
    // A full FIFO still accepts a message when the head leaves in the same
    // cycle; the new entry lands in the slot being freed.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .ck  (ck),
        .rst (rst),
        .inc (push),
        .ptr (wr_ptr)
    );

    ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .ck  (ck),
        .rst (rst),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // One write-enabled register per entry; storage is intentionally not
    // reset, only the pointers/count define what is valid.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge ck) begin
                if (push && !rst && (wr_ptr == PW'(gi))) begin
                    mem_reg[gi] <= in_msg;
                end
            end
        end
    endgenerate

    assign out_msg = pay'(mem_reg[rd_ptr]);

    // ------------------------------------------------------------------
    // Occupancy and overflow
    // ------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_comb begin
        overflow_next = overflow_reg;
        // A drop in the same cycle as clr_ovf keeps the flag set.
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_ovf) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    assign count    = count_reg;
    assign overflow = overflow_reg;

`ifdef MSG_RX_FIFO_DROP_CNT_EN
    // ------------------------------------------------------------------
    // Saturating dropped-message counter
    // ------------------------------------------------------------------
    logic [DROP_W-1:0] drop_cnt_reg;
    logic [DROP_W-1:0] drop_cnt_next;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (clr_ovf) begin
            // Clear restarts the count, counting a drop that coincides.
            drop_cnt_next = drop ? DROP_W'(1) : '0;
        end else if (drop && (drop_cnt_reg != '1)) begin
            drop_cnt_next = drop_cnt_reg + DROP_W'(1);
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule : msg_rx_fifo

// File: tb/tb_msg_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_msg_rx_fifo
// Directed bench for msg_rx_fifo (DEPTH=4). Inputs are changed 1 ns after
// each rising edge and outputs are checked at that same point, i.e. they
// reflect the state registered at the preceding edge.
// Works with or without MSG_RX_FIFO_DROP_CNT_EN defined.
// ----------------------------------------------------------------------------
module tb_msg_rx_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          ck;
    logic          rst;
    logic          in_valid;
    logic [31:0]   in_msg;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_msg;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          clr_ovf;
`ifdef MSG_RX_FIFO_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    msg_rx_fifo #(.DEPTH(DEPTH)) dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_msg    (in_msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_msg   (out_msg),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef MSG_RX_FIFO_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic push_one(input logic [31:0] m);
        in_valid = 1'b1;
        in_msg   = m;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] m);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(tag, out_msg, m);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_msg = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_count",    {{(32-CW){1'b0}}, count}, 32'd0);
        check("rst_empty",    {31'd0, empty},     32'd1);
        check("rst_full",     {31'd0, full},      32'd0);
        check("rst_outvalid", {31'd0, out_valid}, 32'd0);
        check("rst_overflow", {31'd0, overflow},  32'd0);
`ifdef MSG_RX_FIFO_DROP_CNT_EN
        check("rst_dropcnt",  {24'd0, drop_cnt},  32'd0);
`endif

        // Single push, visible one edge later, then popped
        push_one(32'hDEADBEEF);
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_msg",   out_msg, 32'hDEADBEEF);
        check("single_count", {{(32-CW){1'b0}}, count}, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_empty", {31'd0, empty},     32'd1);
        check("single_ovld",  {31'd0, out_valid}, 32'd0);

        // Fill and overflow: 5th message dropped
        for (int i = 1; i <= 5; i++) push_one(32'(i));
        check("fill_full",     {31'd0, full},     32'd1);
        check("fill_count",    {{(32-CW){1'b0}}, count}, 32'd4);
        check("fill_overflow", {31'd0, overflow}, 32'd1);
`ifdef MSG_RX_FIFO_DROP_CNT_EN
        check("fill_dropcnt",  {24'd0, drop_cnt}, 32'd1);
`endif
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("fill_drain%0d", i), 32'(i));
        check("fill_empty",    {31'd0, empty},    32'd1);
        check("fill_ovf_hold", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("clr_overflow",  {31'd0, overflow}, 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) push_one(32'(i));
        check("fp_full", {31'd0, full}, 32'd1);
        in_valid = 1'b1; in_msg = 32'd9; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("fp_overflow", {31'd0, overflow}, 32'd0);
        check("fp_count",    {{(32-CW){1'b0}}, count}, 32'd4);
        pop_expect("fp_drain2", 32'd2);
        pop_expect("fp_drain3", 32'd3);
        pop_expect("fp_drain4", 32'd4);
        pop_expect("fp_drain9", 32'd9);
        check("fp_empty", {31'd0, empty}, 32'd1);

        // Wrap-around: 10 push/pop pairs
        for (int i = 0; i < 10; i++) begin
            push_one(32'h10 + 32'(i));
            check($sformatf("wrap_count1_%0d", i), {{(32-CW){1'b0}}, count}, 32'd1);
            pop_expect($sformatf("wrap_msg%0d", i), 32'h10 + 32'(i));
            check($sformatf("wrap_count0_%0d", i), {{(32-CW){1'b0}}, count}, 32'd0);
        end

        // clr_ovf priority: drop and clear in the same cycle
        for (int i = 1; i <= 4; i++) push_one(32'h20 + 32'(i));
        in_valid = 1'b1; in_msg = 32'h77; clr_ovf = 1'b1;
        step();
        in_valid = 1'b0;
        check("prio_overflow", {31'd0, overflow}, 32'd1);
        check("prio_count",    {{(32-CW){1'b0}}, count}, 32'd4);
`ifdef MSG_RX_FIFO_DROP_CNT_EN
        check("prio_dropcnt",  {24'd0, drop_cnt}, 32'd1);
`endif
        step();
        clr_ovf = 1'b0;
        check("prio_clr_overflow", {31'd0, overflow}, 32'd0);
`ifdef MSG_RX_FIFO_DROP_CNT_EN
        check("prio_clr_dropcnt",  {24'd0, drop_cnt}, 32'd0);
`endif
        pop_expect("prio_head", 32'h21);
        check("mid_count3", {{(32-CW){1'b0}}, count}, 32'd3);

        // Mid-stream reset with in_valid and out_ready active
        rst = 1'b1; in_valid = 1'b1; in_msg = 32'h55; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("mid_count", {{(32-CW){1'b0}}, count}, 32'd0);
        check("mid_empty", {31'd0, empty},     32'd1);
        check("mid_ovld",  {31'd0, out_valid}, 32'd0);
        check("mid_full",  {31'd0, full},      32'd0);
        push_one(32'hA5A5_0001);
        check("post_rst_count", {{(32-CW){1'b0}}, count}, 32'd1);
        pop_expect("post_rst_msg", 32'hA5A5_0001);
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_msg_rx_fifo
